dbg_host: RTL and testbench
===========================

# dbg_host

Debug host controller driving the pipeline CPU's debug/load port from a byte-stream link such as a UART receiver/transmitter pair. It decodes host commands to halt or run the CPU and to write or read instruction and data memory. It also single-steps the CPU by generating `clk_ld` pulses and returns acknowledgements and read data as response bytes. It is the initiator for the CPU's `debug`, `clk_ld`, `addr`, `din`, `we_im`, `we_dm`, `dout_im` and `dout_dm` signals.

## Interface
- `PULSE_HI`, 2: clk cycles `clk_ld` is high per pulse (≥1).
- `PULSE_LO`, 2: clk cycles `clk_ld` is low after each pulse (≥1).
- `READ_WAIT`, 2: clk cycles between driving `addr` and sampling `dout_*` (≥1).
- `RESET_HALT`, 1: reset value of `debug`.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `rx_data` in 8: command byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the block accepts a byte when `rx_valid && rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the sink accepts the byte when `tx_valid && tx_ready`.
- `debug` out 1: 1 means the CPU is clocked by `clk_ld` (halted/loadable).
- `clk_ld` out 1: step/load clock to the CPU.
- `addr` out 32: word address to the memory debug ports.
- `din` out 32: write data.
- `we_im` out 1: instruction memory write enable.
- `we_dm` out 1: data memory write enable.
- `dout_im` in 32: instruction memory readback.
- `dout_dm` in 32: data memory readback.

## Operation
- Frame format: command byte, then operand bytes, all multi-byte fields little-endian.
  - `0x01` WIM: 4 addr + 4 data bytes.
  - `0x02` WDM: 4 addr + 4 data bytes.
  - `0x03` RIM: 4 addr bytes.
  - `0x04` RDM: 4 addr bytes.
  - `0x05` STEP: 1 count byte N.
  - `0x06` RUN: no operands.
  - `0x07` HALT: no operands.
- Responses:
  - `0xAA` ack for WIM, WDM, STEP, RUN and HALT.
  - Reads return 4 data bytes, LSB first.
  - `0xEE` error.
- Unknown command byte: respond `0xEE` immediately; no operand bytes are consumed.
- WIM/WDM/RIM/RDM/STEP while `debug=0`: consume all operands, take no memory or clock action, respond `0xEE`.
- States:
  - IDLE: `rx_ready=1`.
  - GET_ADDR, GET_DATA, GET_CNT: `rx_ready=1`; a byte counter selects the field byte.
  - WR_SETUP → WR_HI → WR_LO: write sequence.
  - RD_WAIT → RD_SEND: read sequence.
  - STEP_HI ↔ STEP_LO: step loop.
  - SEND: ack or error byte.
  - `rx_ready=0` in every state other than IDLE and the GET states.
- Write sequence:
  - WR_SETUP, 1 cycle: drive `addr`, `din`, and the selected `we_*`=1, with `clk_ld=0`.
  - WR_HI: `PULSE_HI` cycles with `clk_ld=1`.
  - WR_LO: `PULSE_LO` cycles with `clk_ld=0`.
  - `we_*` returns to 0 on exit from WR_LO, then the block sends `0xAA`.
- The write pulse also clocks the CPU pipeline once. This side effect is accepted.
- Read sequence: drive `addr`, wait `READ_WAIT` cycles, latch `dout_im` or `dout_dm` into a shift register, then send 4 bytes.
- STEP: issue N pulses, each `PULSE_HI` high followed by `PULSE_LO` low, with `we_*=0`; then ack. N=0 gives no pulses and an immediate ack.
- RUN sets `debug=0`; HALT sets `debug=1`. The change takes effect the cycle after the command byte is accepted, and the ack follows. RUN/HALT while already in that mode still acks.
- `clk_ld=0` whenever `debug=0`.
- `addr` and `din` hold their last value between commands.

## Timing
- Reset values:
  - `debug=RESET_HALT`
  - `clk_ld=0`, `addr=0`, `din=0`, `we_im=0`, `we_dm=0`
  - `tx_valid=0`, `tx_data=0`
  - state IDLE, so `rx_ready=1`
- All outputs are registered except `rx_ready`, which is decoded from the state.
- `tx_valid` stays high with `tx_data` stable until `tx_ready`; the next byte may present on the following cycle.
- Write latency, from acceptance of the last data byte to `tx_valid`: 1 + `PULSE_HI` + `PULSE_LO` + 1 cycles, which is 6 at defaults.
- Read latency, from acceptance of the last addr byte to the first `tx_valid`: `READ_WAIT` + 1 cycles.
- Reset mid-command aborts the command:
  - `we_*` and `clk_ld` drop asynchronously.
  - Partial frames are discarded.
  - `debug` returns to `RESET_HALT`.
- Bytes offered while `rx_ready=0` are not consumed; the source must hold them.

## Configuration
- `DBG_CHECKSUM_EN` defined:
  - Every frame carries one trailing byte equal to the XOR of all preceding bytes of the frame.
  - On mismatch, take no action and respond `0xEE`.
  - Unknown commands still error immediately.
- `DBG_CHECKSUM_EN` undefined: there is no checksum byte and frames are as listed above.

## Test plan
- WIM with addr=0x00000003, data=0x12345678:
  - `we_im=1`, `addr=3` and `din=0x12345678` during exactly one `clk_ld` rising edge.
  - `we_dm` stays 0.
  - Response `0xAA` arrives 6 cycles after the last byte.
- RDM with addr=5 and `dout_dm=0xDEADBEEF`: responses are `EF`, `BE`, `AD`, `DE`, with `tx_ready` toggled low for 3 cycles mid-stream to exercise holding of `tx_data`.
- STEP N=3 → exactly 3 `clk_ld` pulses of 2 high/2 low cycles, then `0xAA`. STEP N=0 → `0xAA` with no pulse.
- RUN → `debug=0`, `0xAA`. Then WIM → no `we_im` and no `clk_ld` activity, response `0xEE`. Then HALT → `debug=1`, `0xAA`.
- Unknown byte `0x42` → `0xEE`, and a following `0x07` is parsed as a new command. Reset asserted in WR_HI → `clk_ld=0` and `we_im=0` immediately, with `debug=1`.
- With `DBG_CHECKSUM_EN` defined, WDM with a corrupted checksum → `0xEE` and `we_dm` never asserted.

Source files
------------

// File: rtl/dbg_host_if.sv
// Byte-link and CPU debug/load port bundle for dbg_host.
// The master modport is the dbg_host view and the slave modport is the link/CPU side.
interface dbg_host_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        debug;
    logic        clk_ld;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we_im;
    logic        we_dm;
    logic [31:0] dout_im;
    logic [31:0] dout_dm;

    modport master (
        input  rx_data, rx_valid, tx_ready, dout_im, dout_dm,
        output rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din, we_im, we_dm
    );
    modport slave (
        output rx_data, rx_valid, tx_ready, dout_im, dout_dm,
        input  rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din, we_im, we_dm
    );
endinterface

// File: rtl/dbg_host.sv
// Debug host: decodes byte-stream commands into CPU debug-port writes, reads, steps and run/halt.
// Defining DBG_CHECKSUM_EN appends an XOR checksum byte to every known frame.
module dbg_host #(
    parameter int PULSE_HI   = 2,
    parameter int PULSE_LO   = 2,
    parameter int READ_WAIT  = 2,
    parameter bit RESET_HALT = 1'b1
) (
    input logic        clk,
    input logic        rstn,
    dbg_host_if.master bus
);
    localparam logic [7:0] C_WIM  = 8'h01;
    localparam logic [7:0] C_WDM  = 8'h02;
    localparam logic [7:0] C_RIM  = 8'h03;
    localparam logic [7:0] C_RDM  = 8'h04;
    localparam logic [7:0] C_STEP = 8'h05;
    localparam logic [7:0] C_RUN  = 8'h06;
    localparam logic [7:0] C_HALT = 8'h07;
    localparam logic [7:0] ACK    = 8'hAA;
    localparam logic [7:0] ERR    = 8'hEE;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CNT, GET_CSUM,
        WR_SETUP, WR_HI, WR_LO, RD_WAIT, RD_SEND, STEP_HI, STEP_LO, SEND
    } state_t;

`ifdef DBG_CHECKSUM_EN
    localparam state_t FRAME_END = GET_CSUM;
`else
    localparam state_t FRAME_END = SEND;
`endif

    state_t      state;
    logic [1:0]  cnt;
    logic [7:0]  cmd, cnt_r, steps, resp;
    logic [31:0] addr_sh, data_sh, rd_sh;
    logic [15:0] timer;
    logic        rd_dm;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        debug, clk_ld, we_im, we_dm, tx_valid;
    logic [31:0] addr, din;
    logic [7:0]  tx_data;

    logic        rx_ready, acc, fields_done, dispatch;
    logic [7:0]  f_cmd, f_cnt;
    logic [31:0] f_addr, f_data;

    // Field values including the byte being accepted this cycle, so a frame can
    // be dispatched on the same edge that completes it.
    always_comb begin
        rx_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA) ||
                   (state == GET_CNT) || (state == GET_CSUM);
        acc    = bus.rx_valid && rx_ready;
        f_cmd  = (state == IDLE)     ? bus.rx_data : cmd;
        f_addr = (state == GET_ADDR) ? {bus.rx_data, addr_sh[31:8]} : addr_sh;
        f_data = (state == GET_DATA) ? {bus.rx_data, data_sh[31:8]} : data_sh;
        f_cnt  = (state == GET_CNT)  ? bus.rx_data : cnt_r;
        fields_done = ((state == IDLE) && (bus.rx_data == C_RUN || bus.rx_data == C_HALT)) ||
                      ((state == GET_ADDR) && cnt == 2'd3 && (cmd == C_RIM || cmd == C_RDM)) ||
                      ((state == GET_DATA) && cnt == 2'd3) ||
                      (state == GET_CNT);
`ifdef DBG_CHECKSUM_EN
        dispatch = acc && (state == GET_CSUM) && (bus.rx_data == csum);
`else
        dispatch = acc && fields_done;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd      <= '0;
            cnt_r    <= '0;
            steps    <= '0;
            resp     <= '0;
            addr_sh  <= '0;
            data_sh  <= '0;
            rd_sh    <= '0;
            timer    <= '0;
            rd_dm    <= 1'b0;
            debug    <= RESET_HALT;
            clk_ld   <= 1'b0;
            we_im    <= 1'b0;
            we_dm    <= 1'b0;
            addr     <= '0;
            din      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
`ifdef DBG_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
`ifdef DBG_CHECKSUM_EN
            if (acc) csum <= (state == IDLE) ? bus.rx_data : (csum ^ bus.rx_data);
`endif
            case (state)
                IDLE: if (acc) begin
                    cmd <= bus.rx_data;
                    cnt <= 2'd0;
                    if (bus.rx_data >= C_WIM && bus.rx_data <= C_RDM) state <= GET_ADDR;
                    else if (bus.rx_data == C_STEP)                    state <= GET_CNT;
                    else if (fields_done)                              state <= FRAME_END;
                    else begin
                        resp  <= ERR;
                        state <= SEND;
                    end
                end
                GET_ADDR: if (acc) begin
                    addr_sh <= f_addr;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= fields_done ? FRAME_END : GET_DATA;
                end
                GET_DATA: if (acc) begin
                    data_sh <= f_data;
                    cnt     <= cnt + 2'd1;
                    if (fields_done) state <= FRAME_END;
                end
                GET_CNT: if (acc) begin
                    cnt_r <= f_cnt;
                    state <= FRAME_END;
                end
`ifdef DBG_CHECKSUM_EN
                GET_CSUM: if (acc && !dispatch) begin
                    resp  <= ERR;
                    state <= SEND;
                end
`endif
                WR_SETUP: begin
                    clk_ld <= 1'b1;
                    timer  <= 16'(PULSE_HI - 1);
                    state  <= WR_HI;
                end
                WR_HI: if (timer == '0) begin
                    clk_ld <= 1'b0;
                    timer  <= 16'(PULSE_LO - 1);
                    state  <= WR_LO;
                end else timer <= timer - 16'd1;
                WR_LO: if (timer == '0) begin
                    we_im <= 1'b0;
                    we_dm <= 1'b0;
                    resp  <= ACK;
                    state <= SEND;
                end else timer <= timer - 16'd1;
                RD_WAIT: if (timer == '0) begin
                    rd_sh <= rd_dm ? bus.dout_dm : bus.dout_im;
                    cnt   <= 2'd0;
                    state <= RD_SEND;
                end else timer <= timer - 16'd1;
                // Next byte is presented on the handshake edge so a ready sink sees no gaps.
                RD_SEND: if (!tx_valid) begin
                    tx_valid <= 1'b1;
                    tx_data  <= rd_sh[7:0];
                    rd_sh    <= rd_sh >> 8;
                end else if (bus.tx_ready) begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tx_data <= rd_sh[7:0];
                        rd_sh   <= rd_sh >> 8;
                    end
                end
                STEP_HI: if (timer == '0) begin
                    clk_ld <= 1'b0;
                    timer  <= 16'(PULSE_LO - 1);
                    state  <= STEP_LO;
                end else timer <= timer - 16'd1;
                STEP_LO: if (timer == '0) begin
                    if (steps == 8'd1) begin
                        resp  <= ACK;
                        state <= SEND;
                    end else begin
                        steps  <= steps - 8'd1;
                        clk_ld <= 1'b1;
                        timer  <= 16'(PULSE_HI - 1);
                        state  <= STEP_HI;
                    end
                end else timer <= timer - 16'd1;
                SEND: if (!tx_valid) begin
                    tx_valid <= 1'b1;
                    tx_data  <= resp;
                end else if (bus.tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A complete, valid frame overrides whatever the field states chose.
            if (dispatch) begin
                state <= SEND;
                resp  <= ERR;
                case (f_cmd)
                    C_RUN: begin
                        debug <= 1'b0;
                        resp  <= ACK;
                    end
                    C_HALT: begin
                        debug <= 1'b1;
                        resp  <= ACK;
                    end
                    default: if (debug) begin
                        if (f_cmd == C_WIM || f_cmd == C_WDM) begin
                            addr  <= f_addr;
                            din   <= f_data;
                            we_im <= (f_cmd == C_WIM);
                            we_dm <= (f_cmd == C_WDM);
                            state <= WR_SETUP;
                        end else if (f_cmd == C_RIM || f_cmd == C_RDM) begin
                            addr  <= f_addr;
                            rd_dm <= (f_cmd == C_RDM);
                            timer <= 16'(READ_WAIT - 1);
                            state <= RD_WAIT;
                        end else if (f_cnt != 8'd0) begin
                            steps  <= f_cnt;
                            clk_ld <= 1'b1;
                            timer  <= 16'(PULSE_HI - 1);
                            state  <= STEP_HI;
                        end else resp <= ACK;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign bus.debug    = debug;
    assign bus.clk_ld   = clk_ld;
    assign bus.addr     = addr;
    assign bus.din      = din;
    assign bus.we_im    = we_im;
    assign bus.we_dm    = we_dm;
endmodule

// File: tb/tb_dbg_host.sv
// Bench for dbg_host: directed and random command frames against a memory/response reference model.
module tb_dbg_host;
    localparam int PH = 2;
    localparam int PL = 2;
    localparam int RW = 2;
    localparam logic [7:0] ACK = 8'hAA;
    localparam logic [7:0] ERR = 8'hEE;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    always #5 clk = ~clk;

    dbg_host_if bus();
    dbg_host #(.PULSE_HI(PH), .PULSE_LO(PL), .READ_WAIT(RW), .RESET_HALT(1'b1))
        dut (.clk(clk), .rstn(rstn), .bus(bus));

    // CPU-side memories written by the DUT's load pulses, plus the model's view.
    logic [31:0] imem [16] = '{default: 32'h0};
    logic [31:0] dmem [16] = '{default: 32'h0};
    logic [31:0] m_im [16] = '{default: 32'h0};
    logic [31:0] m_dm [16] = '{default: 32'h0};
    logic        m_debug = 1'b1;
    int pulses = 0, im_wr = 0, dm_wr = 0, we_cyc = 0;
    int hi_bad = 0, lo_bad = 0, hi_run = 0, lo_run = 100;
    logic [7:0] frame[$];

    assign bus.dout_im = imem[bus.addr[3:0]];
    assign bus.dout_dm = dmem[bus.addr[3:0]];

    always @(posedge bus.clk_ld) begin
        pulses++;
        if (bus.we_im) begin imem[bus.addr[3:0]] = bus.din; im_wr++; end
        if (bus.we_dm) begin dmem[bus.addr[3:0]] = bus.din; dm_wr++; end
    end

    always @(negedge clk) begin
        if (bus.we_im || bus.we_dm) we_cyc++;
        if (bus.clk_ld) begin
            if (hi_run == 0 && lo_run < PL) lo_bad++;
            hi_run++;
            lo_run = 0;
        end else begin
            if (hi_run != 0 && hi_run != PH) hi_bad++;
            hi_run = 0;
            lo_run++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("rx_accept", bus.rx_ready, 1'b1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [7:0] b, output int lat);
        lat = 0;
        while (bus.tx_valid !== 1'b1 && lat < 500) begin @(posedge clk); #1; lat++; end
        check("tx_wait", bus.tx_valid, 1'b1);
        b = bus.tx_data;
        @(posedge clk); #1;
    endtask

    task automatic build_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                               input logic [7:0] n);
`ifdef DBG_CHECKSUM_EN
        logic [7:0] cs;
`endif
        frame.delete();
        frame.push_back(c);
        if (c >= 8'd1 && c <= 8'd4) for (int i = 0; i < 4; i++) frame.push_back(a[8*i +: 8]);
        if (c == 8'd1 || c == 8'd2) for (int i = 0; i < 4; i++) frame.push_back(d[8*i +: 8]);
        if (c == 8'd5) frame.push_back(n);
`ifdef DBG_CHECKSUM_EN
        if (c >= 8'd1 && c <= 8'd7) begin
            cs = 8'h00;
            foreach (frame[i]) cs ^= frame[i];
            frame.push_back(cs);
        end
`endif
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] n, input bit bad, input bit hold);
        logic [7:0] exp[$];
        logic [7:0] b;
        logic [31:0] word;
        int lat, lat_exp, e_pul, e_imw, e_dmw;
        int p0, i0, d0, w0, h0, l0;
        bit wr_ok, rd_ok;
        e_pul = 0; e_imw = 0; e_dmw = 0; wr_ok = 0; rd_ok = 0;
        build_frame(c, a, d, n);
`ifdef DBG_CHECKSUM_EN
        if (bad) frame[frame.size()-1] ^= 8'h5A;
`endif
        if (c == 8'd0 || c > 8'd7 || bad) exp.push_back(ERR);
        else if (c == 8'd6) begin m_debug = 1'b0; exp.push_back(ACK); end
        else if (c == 8'd7) begin m_debug = 1'b1; exp.push_back(ACK); end
        else if (!m_debug) exp.push_back(ERR);
        else begin
            case (c)
                8'd1: begin m_im[a[3:0]] = d; e_pul = 1; e_imw = 1; wr_ok = 1; end
                8'd2: begin m_dm[a[3:0]] = d; e_pul = 1; e_dmw = 1; wr_ok = 1; end
                8'd3, 8'd4: begin
                    word = (c == 8'd3) ? m_im[a[3:0]] : m_dm[a[3:0]];
                    for (int i = 0; i < 4; i++) exp.push_back(word[8*i +: 8]);
                    rd_ok = 1;
                end
                default: e_pul = int'(n);
            endcase
            if (!rd_ok) exp.push_back(ACK);
        end
        lat_exp = wr_ok ? (1 + PH + PL + 1) : (rd_ok ? (RW + 1) : -1);

        p0 = pulses; i0 = im_wr; d0 = dm_wr; w0 = we_cyc; h0 = hi_bad; l0 = lo_bad;
        foreach (frame[k]) send_byte(frame[k]);
        foreach (exp[k]) begin
            get_resp(b, lat);
            check({tag, "_resp"}, b, exp[k]);
            if (k == 0 && lat_exp > 0) check({tag, "_lat"}, lat, lat_exp);
            if (k == 1 && hold) begin
                bus.tx_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check({tag, "_hold_v"}, bus.tx_valid, 1'b1);
                    check({tag, "_hold_d"}, bus.tx_data, exp[2]);
                end
                bus.tx_ready = 1'b1;
            end
        end
        repeat (2) @(posedge clk); #1;
        check({tag, "_pulses"}, pulses - p0, e_pul);
        check({tag, "_imw"}, im_wr - i0, e_imw);
        check({tag, "_dmw"}, dm_wr - d0, e_dmw);
        check({tag, "_wecyc"}, we_cyc - w0, (e_imw + e_dmw) * (1 + PH + PL));
        check({tag, "_hiw"}, hi_bad - h0, 0);
        check({tag, "_low"}, lo_bad - l0, 0);
        check({tag, "_debug"}, bus.debug, m_debug);
        check({tag, "_idle"}, {bus.clk_ld, bus.tx_valid, bus.rx_ready}, 3'b001);
        if (wr_ok || rd_ok) check({tag, "_addr"}, bus.addr, a);
        if (wr_ok) check({tag, "_din"}, bus.din, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd;
        int r, n;
        logic [7:0] c;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        #12;
        check("rst_rx_ready", bus.rx_ready, 1'b1);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_debug", bus.debug, 1'b1);
        check("rst_clk_ld", bus.clk_ld, 1'b0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_din", bus.din, 32'h0);
        check("rst_we", {bus.we_im, bus.we_dm}, 2'b00);
        @(negedge clk); rstn = 1'b1;

        run_cmd("wim", 8'h01, 32'h3, 32'h12345678, 8'd0, 1'b0, 1'b0);
        check("wim_mem", imem[3], 32'h12345678);
        run_cmd("wdm", 8'h02, 32'h5, 32'hDEADBEEF, 8'd0, 1'b0, 1'b0);
        run_cmd("rdm", 8'h04, 32'h5, 32'h0, 8'd0, 1'b0, 1'b1);
        run_cmd("step3", 8'h05, 32'h0, 32'h0, 8'd3, 1'b0, 1'b0);
        run_cmd("step0", 8'h05, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
        run_cmd("run", 8'h06, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
        run_cmd("wim_run", 8'h01, 32'h4, 32'hA5A5A5A5, 8'd0, 1'b0, 1'b0);
        run_cmd("halt", 8'h07, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
        run_cmd("unk", 8'h42, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
        run_cmd("halt2", 8'h07, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
`ifdef DBG_CHECKSUM_EN
        run_cmd("cs_bad", 8'h02, 32'h9, 32'hCAFEF00D, 8'd0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 19));
            ra = $urandom();
            rd = $urandom();
            n  = int'($urandom_range(0, 4));
            if (r < 4)       c = 8'h01;
            else if (r < 7)  c = 8'h02;
            else if (r < 10) c = 8'h03;
            else if (r < 13) c = 8'h04;
            else if (r < 16) c = 8'h05;
            else if (r == 16) c = 8'h06;
            else if (r == 17) c = 8'h07;
            else c = 8'($urandom_range(8, 255));
            run_cmd("rnd", c, ra, rd, 8'(n), 1'b0, 1'b0);
        end

        // Reset while the write pulse is high.
        run_cmd("pre_rst_halt", 8'h07, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0);
        rd = $urandom();
        build_frame(8'h01, 32'h7, rd, 8'd0);
        foreach (frame[k]) send_byte(frame[k]);
        n = 0;
        while (bus.clk_ld !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("rst_wr_hi", {bus.clk_ld, bus.we_im}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_clk_ld", bus.clk_ld, 1'b0);
        check("rst_mid_we_im", bus.we_im, 1'b0);
        check("rst_mid_debug", bus.debug, 1'b1);
        check("rst_mid_rx_ready", bus.rx_ready, 1'b1);
        m_im[7] = rd;
        m_debug = 1'b1;
        @(negedge clk); rstn = 1'b1;
        run_cmd("post_rst_rim", 8'h03, 32'h7, 32'h0, 8'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
